// File: rtl/signext_pkg.sv
// rtl/signext_pkg.sv - shared types for the pipelined immediate extender
package signext_pkg;

    typedef enum logic [1:0] {
        SEXT     = 2'b00,
        ZEXT     = 2'b01,
        SEXT_SHL = 2'b10,
        PREFIX   = 2'b11
    } imm_mode_t;

    typedef enum logic {
        IDLE     = 1'b0,
        PREFIXED = 1'b1
    } state_t;

endpackage

// File: rtl/skid_buf.sv
// rtl/skid_buf.sv - two-entry valid/ready buffer: output register plus one skid register
module skid_buf #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire;
    logic             out_free;

    // in_ready comes straight from a flop so upstream sees no combinational path
    assign in_ready = !skid_valid;
    assign in_fire  = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_free) begin
            // skid is always older than anything arriving now; in_fire cannot coincide with skid_valid
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/signext_pipe.sv
// rtl/signext_pipe.sv - pipelined immediate extender with prefix support and skid-buffered output
module signext_pipe
    import signext_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16,
    parameter int SHL   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic             out_prefixed
);

    imm_mode_t         mode;
    state_t            state, state_n;
    logic [IN_W-1:0]   pfx_reg, pfx_n;
    logic              accept;
    logic              push;
    logic [2*IN_W-1:0] src_long;
    logic [OUT_W-1:0]  sext_val, zext_val, res;
    logic              res_prefixed;

    assign mode     = imm_mode_t'(in_mode);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (mode != PREFIX);
    assign src_long = {pfx_reg, in_imm};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pfx_reg <= '0;
        end else begin
            state   <= state_n;
            pfx_reg <= pfx_n;
        end
    end

    // A second prefix replaces the first rather than widening further
    always_comb begin
        state_n = state;
        pfx_n   = pfx_reg;
        if (accept) begin
            if (mode == PREFIX) begin
                pfx_n   = in_imm;
                state_n = PREFIXED;
            end else begin
                state_n = IDLE;
            end
        end
    end

    always_comb begin
        res_prefixed = (state == PREFIXED);
        if (res_prefixed) begin
            sext_val = OUT_W'($signed(src_long));
            zext_val = OUT_W'(src_long);
        end else begin
            sext_val = OUT_W'($signed(in_imm));
            zext_val = OUT_W'(in_imm);
        end
        case (mode)
            ZEXT:     res = zext_val;
            SEXT_SHL: res = sext_val << SHL;
            default:  res = sext_val;
        endcase
    end

    skid_buf #(
        .WIDTH(OUT_W + 1)
    ) u_skid_buf (
        .clk      (clk),
        .reset    (reset),
        .in_valid (push),
        .in_ready (in_ready),
        .in_data  ({res_prefixed, res}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data ({out_prefixed, out_imm})
    );

endmodule

// File: tb/tb_signext_pipe.sv
// tb/tb_signext_pipe.sv - self-checking bench for signext_pipe
module tb_signext_pipe;
    import signext_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic        out_prefixed;

    signext_pipe #(.IN_W(4), .OUT_W(16), .SHL(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_imm      (in_imm),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_prefixed(out_prefixed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] imm;
        logic        pfx;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  imm;
        logic        produce;
        logic [15:0] exp_imm;
        logic        exp_pfx;
    } vec_t;

    exp_t q[$];
    vec_t tbl[17];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_output: got %h expected no output", out_imm);
            end else begin
                e = q.pop_front();
                chk("out_imm", 32'(out_imm), 32'(e.imm));
                chk("out_prefixed", 32'(out_prefixed), 32'(e.pfx));
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [3:0] v, input logic produce,
                        input logic [15:0] ei, input logic ep);
        bit done = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_imm   = v;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (produce) q.push_back({ei, ep});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: got in_ready=0 for 20 cycles expected accept");
        end
        in_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{SEXT_SHL, 4'h7, 1'b1, 16'h000E, 1'b0};
        tbl[1]  = '{SEXT_SHL, 4'h8, 1'b1, 16'hFFF0, 1'b0};
        tbl[2]  = '{PREFIX,   4'h8, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{SEXT,     4'h3, 1'b1, 16'hFF83, 1'b1};
        tbl[4]  = '{ZEXT,     4'h3, 1'b1, 16'h0003, 1'b0};
        tbl[5]  = '{PREFIX,   4'h1, 1'b0, 16'h0000, 1'b0};
        tbl[6]  = '{PREFIX,   4'h8, 1'b0, 16'h0000, 1'b0};
        tbl[7]  = '{ZEXT,     4'hF, 1'b1, 16'h008F, 1'b1};
        tbl[8]  = '{SEXT,     4'h7, 1'b1, 16'h0007, 1'b0};
        tbl[9]  = '{ZEXT,     4'h8, 1'b1, 16'h0008, 1'b0};
        tbl[10] = '{PREFIX,   4'h7, 1'b0, 16'h0000, 1'b0};
        tbl[11] = '{SEXT,     4'hF, 1'b1, 16'h007F, 1'b1};
        tbl[12] = '{PREFIX,   4'h7, 1'b0, 16'h0000, 1'b0};
        tbl[13] = '{SEXT_SHL, 4'hF, 1'b1, 16'h00FE, 1'b1};
        tbl[14] = '{PREFIX,   4'hF, 1'b0, 16'h0000, 1'b0};
        tbl[15] = '{SEXT_SHL, 4'h0, 1'b1, 16'hFFE0, 1'b1};
        tbl[16] = '{SEXT_SHL, 4'h0, 1'b1, 16'h0000, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_imm    = 4'h0;
        in_mode   = 2'b00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_imm", 32'(out_imm), 32'd0);
        chk("reset_out_prefixed", 32'(out_prefixed), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // back-to-back SEXT/ZEXT: one-cycle latency, no bubble between results
        send(SEXT, 4'hA, 1'b1, 16'hFFFA, 1'b0);
        chk("lat1_out_valid", 32'(out_valid), 32'd1);
        chk("lat1_out_imm", 32'(out_imm), 32'h0000FFFA);
        send(ZEXT, 4'hA, 1'b1, 16'h000A, 1'b0);
        chk("nobubble_out_valid", 32'(out_valid), 32'd1);
        chk("nobubble_out_imm", 32'(out_imm), 32'h0000000A);

        for (int i = 0; i < 17; i++)
            send(tbl[i].mode, tbl[i].imm, tbl[i].produce, tbl[i].exp_imm, tbl[i].exp_pfx);
        repeat (3) @(posedge clk);
        #1;

        // backpressure: two entries fill, in_ready drops, output holds
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = SEXT;
        in_imm    = 4'h1;
        @(negedge clk);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        q.push_back({16'h0001, 1'b0});
        @(posedge clk);
        #1;
        in_imm = 4'h2;
        @(negedge clk);
        chk("bp_ready2", 32'(in_ready), 32'd1);
        q.push_back({16'h0002, 1'b0});
        @(posedge clk);
        #1;
        in_imm = 4'h3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready_low", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_imm", 32'(out_imm), 32'h00000001);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(SEXT, 4'h3, 1'b1, 16'h0003, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // asynchronous reset mid-cycle with a pending prefix and a held result
        out_ready = 1'b0;
        send(SEXT, 4'h5, 1'b0, 16'h0000, 1'b0);
        send(PREFIX, 4'hF, 1'b0, 16'h0000, 1'b0);
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_imm", 32'(out_imm), 32'd0);
        chk("async_out_prefixed", 32'(out_prefixed), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        @(posedge clk);
        #3;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(SEXT, 4'h3, 1'b1, 16'h0003, 1'b0);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d outputs pending expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/signext_pipe.md
# signext_pipe

Parametrised, pipelined immediate extender. It is the successor to the fixed 4-to-16 sign extender in the decode stage. It accepts an immediate field with a mode over a valid/ready handshake and widens it from IN_W to OUT_W bits by sign extension, zero extension or sign extension plus left shift. It also supports a PREFIX mode, which latches the upper chunk of an immediate so the next instruction builds a 2·IN_W-bit immediate. Output is registered and backed by a one-entry skid buffer, so decode can stall without losing immediates.

## Interface
- IN_W, 4, immediate field width; legal values are 2 ≤ IN_W and 2·IN_W ≤ OUT_W
- OUT_W, 16, datapath width
- SHL, 1, left-shift amount for SEXT_SHL (branch offsets); legal values are 0 ≤ SHL < OUT_W
- clk  in  1  the single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  producer holds a valid immediate
- in_ready  out  1  block can accept this cycle; driven from a register only
- in_imm  in  IN_W  raw immediate field
- in_mode  in  2  00 SEXT, 01 ZEXT, 10 SEXT_SHL, 11 PREFIX
- out_valid  out  1  out_imm is valid
- out_ready  in  1  consumer accepts out_imm
- out_imm  out  OUT_W  extended immediate
- out_prefixed  out  1  out_imm was built from a prefix plus the current chunk

## Operation
- Accept occurs when in_valid && in_ready.
- State machine states:
  - IDLE: an accepted PREFIX loads pfx_reg ← in_imm and moves to PREFIXED. No output is produced. An accepted non-PREFIX computes the result from src = in_imm (n = IN_W) and stays in IDLE.
  - PREFIXED: an accepted non-PREFIX uses src = {pfx_reg, in_imm} (n = 2·IN_W), sets out_prefixed = 1 and returns to IDLE. An accepted PREFIX overwrites pfx_reg and stays in PREFIXED; prefixes do not chain.
- Arithmetic:
  - SEXT: bits [n-1:0] = src; bits [OUT_W-1:n] = src[n-1].
  - ZEXT: upper bits = 0.
  - SEXT_SHL: SEXT result shifted left by SHL. Bits shifted past OUT_W are dropped. Low bits are zero-filled.
- Buffering:
  - Storage is the output register plus one skid register (2 entries total). Order is strictly FIFO.
  - in_ready = !skid_valid.
  - An accepted result goes to the output register if it is empty or draining this cycle; otherwise it goes to the skid register.
  - When the output register drains and skid_valid = 1, the skid entry moves to the output register.
- PREFIX accepts never occupy a storage entry. They are accepted whenever in_ready = 1.
- Reset, including mid-operation: out_valid = 0, out_imm = 0, out_prefixed = 0, skid_valid = 0, in_ready = 1, state = IDLE, pfx_reg = 0. A pending prefix and any buffered results are discarded.

## Timing
- Latency: an accept in cycle t gives out_valid in cycle t+1 when the output register is free.
- The output register holds out_imm and out_prefixed stable while out_valid && !out_ready.
- in_ready has no combinational path from out_ready or in_valid. It falls the cycle after the skid register fills and rises the cycle after the skid register drains.
- Same-cycle drain and accept with an empty skid register: the new result loads straight into the output register, with no bubble. Full throughput is 1 per cycle while out_ready = 1.
- Same-cycle drain and accept with a full skid register cannot occur, because in_ready = 0.

## Structure
- Shared package signext_pkg holds:
  - typedef enum logic [1:0] imm_mode_t {SEXT, ZEXT, SEXT_SHL, PREFIX}
  - typedef enum logic state_t {IDLE, PREFIXED}
- One sub-module, skid_buf, parametrised by WIDTH = OUT_W+1 (data plus prefixed flag). It implements the two-entry valid/ready buffer.
- Extension logic is combinational in the top level and feeds skid_buf.

## Test plan
Parameters for all scenarios: IN_W=4, OUT_W=16, SHL=1, out_ready=1 unless stated.
1. SEXT 4'hA, then ZEXT 4'hA, back-to-back → out_imm 16'hFFFA then 16'h000A on consecutive cycles; out_prefixed 0; no bubble.
2. SEXT_SHL 4'h7, then SEXT_SHL 4'h8 → 16'h000E, then 16'hFFF0.
3. PREFIX 4'h8, then SEXT 4'h3 → a single output 16'hFF83 with out_prefixed = 1. Then ZEXT 4'h3 → 16'h0003 with out_prefixed = 0.
4. PREFIX 4'h1, PREFIX 4'h8, then ZEXT 4'hF → 16'h008F. No output is produced for either prefix.
5. out_ready = 0, present SEXT 4'h1, 4'h2, 4'h3 continuously:
   - 4'h1 and 4'h2 are accepted.
   - in_ready = 0 from the cycle after the second accept.
   - out_imm holds 16'h0001.
   - Raising out_ready delivers 0001, 0002, 0003 in order with none lost.
6. PREFIX 4'hF, then assert reset asynchronously mid-cycle → out_valid drops immediately. After release, SEXT 4'h3 → 16'h0003 with out_prefixed = 0.
